// File: rtl/fir_seq_ctrl.sv
// rtl/fir_seq_ctrl.sv - pin strobe sequencer feeding coefficient loads and samples into a FIR
// Turns a slow async strobe into single-cycle FIR transfers and captures the result after latency.
module fir_seq_ctrl #(
  parameter int NUM_TAPS    = 4,
  parameter int FIR_LATENCY = 2,
  parameter int DATA_W      = 8,
  parameter int OUT_W       = 14,
  localparam int IDX_W      = $clog2(NUM_TAPS),
  localparam int CNT_W      = $clog2(FIR_LATENCY + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DATA_W-1:0] din,
  input  logic              strobe,
  input  logic              mode,
  output logic [DATA_W-1:0] fir_x,
  output logic              fir_tvalid,
  output logic              fir_set_coeffs,
  input  logic [OUT_W-1:0]  fir_y,
  output logic [OUT_W-1:0]  y_out,
  output logic              y_valid,
  output logic              coeffs_ready,
  output logic [IDX_W-1:0]  coeff_idx,
  output logic              busy,
  output logic              err_nocoef,
  output logic              err_overrun
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FIR_LATENCY - 1);

  state_t             state_q, state_d;
  logic               sync1_q, sync2_q, sync3_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  fir_x_d;
  logic               fir_tvalid_d, fir_set_coeffs_d;
  logic [OUT_W-1:0]   y_out_d;
  logic               y_valid_d;
  logic               coeffs_ready_d;
  logic [IDX_W-1:0]   coeff_idx_d;
  logic               err_nocoef_d, err_overrun_d;
  logic               strobe_event;

  // sync3 exists only to detect the rising edge of the synchronized strobe
  assign strobe_event = sync2_q & ~sync3_q & ena;
  assign busy         = (state_q == S_WAIT) || (state_q == S_CAPTURE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      sync3_q        <= 1'b0;
      cnt_q          <= '0;
      fir_x          <= '0;
      fir_tvalid     <= 1'b0;
      fir_set_coeffs <= 1'b0;
      y_out          <= '0;
      y_valid        <= 1'b0;
      coeffs_ready   <= 1'b0;
      coeff_idx      <= '0;
      err_nocoef     <= 1'b0;
      err_overrun    <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync1_q        <= strobe;
      sync2_q        <= sync1_q;
      sync3_q        <= sync2_q;
      cnt_q          <= cnt_d;
      fir_x          <= fir_x_d;
      fir_tvalid     <= fir_tvalid_d;
      fir_set_coeffs <= fir_set_coeffs_d;
      y_out          <= y_out_d;
      y_valid        <= y_valid_d;
      coeffs_ready   <= coeffs_ready_d;
      coeff_idx      <= coeff_idx_d;
      err_nocoef     <= err_nocoef_d;
      err_overrun    <= err_overrun_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    fir_x_d          = fir_x;
    fir_tvalid_d     = 1'b0;
    fir_set_coeffs_d = 1'b0;
    y_out_d          = y_out;
    y_valid_d        = 1'b0;
    coeffs_ready_d   = coeffs_ready;
    coeff_idx_d      = coeff_idx;
    err_nocoef_d     = err_nocoef;
    err_overrun_d    = err_overrun;

    case (state_q)
      S_IDLE: begin
        if (strobe_event) begin
          if (mode) begin
            fir_tvalid_d     = 1'b1;
            fir_set_coeffs_d = 1'b1;
            fir_x_d          = din;
            // Starting a new set invalidates the old one until it is complete
            if (coeff_idx == '0) coeffs_ready_d = 1'b0;
            if (coeff_idx == LAST_IDX) begin
              coeff_idx_d    = '0;
              coeffs_ready_d = 1'b1;
            end else begin
              coeff_idx_d = coeff_idx + 1'b1;
            end
          end else if (!coeffs_ready || coeff_idx != '0) begin
            err_nocoef_d = 1'b1;
          end else begin
            fir_tvalid_d = 1'b1;
            fir_x_d      = din;
            cnt_d        = CNT_INIT;
            state_d      = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (strobe_event) err_overrun_d = 1'b1;
        if (cnt_q == '0) state_d = S_CAPTURE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_CAPTURE: begin
        if (strobe_event) err_overrun_d = 1'b1;
        y_out_d   = fir_y;
        y_valid_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb/tb_fir_seq_ctrl.sv - scoreboard bench for fir_seq_ctrl
// Stimulus pushes expected FIR transfers and results; a negedge monitor pops and compares.
module tb_fir_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic [7:0]  din = '0;
  logic        strobe = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  fir_x;
  logic        fir_tvalid;
  logic        fir_set_coeffs;
  logic [13:0] fir_y = '0;
  logic [13:0] y_out;
  logic        y_valid;
  logic        coeffs_ready;
  logic [1:0]  coeff_idx;
  logic        busy;
  logic        err_nocoef;
  logic        err_overrun;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct { logic sc; logic [7:0] x; int cyc; } tv_t;
  typedef struct { logic [13:0] y; int cyc; } yv_t;
  tv_t tv_q[$];
  yv_t y_q[$];

  fir_seq_ctrl #(.NUM_TAPS(4), .FIR_LATENCY(2), .DATA_W(8), .OUT_W(14)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .din(din), .strobe(strobe), .mode(mode),
    .fir_x(fir_x), .fir_tvalid(fir_tvalid), .fir_set_coeffs(fir_set_coeffs),
    .fir_y(fir_y), .y_out(y_out), .y_valid(y_valid), .coeffs_ready(coeffs_ready),
    .coeff_idx(coeff_idx), .busy(busy), .err_nocoef(err_nocoef), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (fir_tvalid) begin
        if (tv_q.size() == 0) begin
          check("unexpected_tvalid", 32'(fir_x), 32'hFFFF_FFFF);
        end else begin
          tv_t e;
          e = tv_q.pop_front();
          check("tvalid_set_coeffs", 32'(fir_set_coeffs), 32'(e.sc));
          check("tvalid_fir_x", 32'(fir_x), 32'(e.x));
          check("tvalid_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else if (fir_set_coeffs) begin
        check("set_coeffs_without_tvalid", 32'(fir_set_coeffs), 32'd0);
      end
      if (y_valid) begin
        if (y_q.size() == 0) begin
          check("unexpected_y_valid", 32'(y_out), 32'hFFFF_FFFF);
        end else begin
          yv_t e;
          e = y_q.pop_front();
          check("y_out", 32'(y_out), 32'(e.y));
          check("y_valid_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // Strobe raised on a negedge at cycle k: transfer expected at k+3, result at k+6
  task automatic send(input logic [7:0] d, input logic m, input bit exp_tv,
                      input bit exp_y, input logic [13:0] yv);
    int k;
    @(negedge clk);
    k = cyc;
    din = d; mode = m; strobe = 1'b1;
    if (exp_tv) tv_q.push_back('{sc: m, x: d, cyc: k + 3});
    if (exp_y)  y_q.push_back('{y: yv, cyc: k + 6});
    repeat (4) @(negedge clk);
    strobe = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    logic [1:0] exp_idx [4];
    exp_idx[0] = 2'd1; exp_idx[1] = 2'd2; exp_idx[2] = 2'd3; exp_idx[3] = 2'd0;

    repeat (2) @(negedge clk);
    check("reset_outputs",
          32'({fir_x, fir_tvalid, fir_set_coeffs, y_out, y_valid, coeffs_ready,
               coeff_idx, busy, err_nocoef, err_overrun}), 32'd0);
    rst_n = 1'b1;

    // Sample before any coefficients: rejected
    send(8'h55, 1'b0, 1'b0, 1'b0, '0);
    check("nocoef_flag", 32'(err_nocoef), 32'd1);
    check("nocoef_ready", 32'(coeffs_ready), 32'd0);
    check("nocoef_busy", 32'(busy), 32'd0);
    do_reset();
    check("sticky_cleared", 32'(err_nocoef), 32'd0);

    // Full coefficient load
    for (int i = 0; i < 4; i++) begin
      send(8'(i + 1), 1'b1, 1'b1, 1'b0, '0);
      check("load_idx", 32'(coeff_idx), 32'(exp_idx[i]));
      check("load_ready", 32'(coeffs_ready), (i == 3) ? 32'd1 : 32'd0);
    end

    // Normal sample
    fir_y = 14'h1ABC;
    send(8'h10, 1'b0, 1'b1, 1'b1, 14'h1ABC);
    fir_y = 14'h0000;
    repeat (3) @(negedge clk);
    check("y_out_held", 32'(y_out), 32'h1ABC);
    check("no_err_after_sample", 32'({err_nocoef, err_overrun}), 32'd0);

    // ena low: strobe ignored
    ena = 1'b0;
    send(8'hEE, 1'b1, 1'b0, 1'b0, '0);
    check("ena_low_idx", 32'(coeff_idx), 32'd0);
    check("ena_low_ready", 32'(coeffs_ready), 32'd1);
    ena = 1'b1;

    // Second strobe lands during WAIT
    fir_y = 14'h0123;
    @(negedge clk);
    k = cyc;
    din = 8'h30; mode = 1'b0; strobe = 1'b1;
    tv_q.push_back('{sc: 1'b0, x: 8'h30, cyc: k + 3});
    y_q.push_back('{y: 14'h0123, cyc: k + 6});
    @(negedge clk); strobe = 1'b0;
    @(negedge clk); strobe = 1'b1;
    repeat (2) @(negedge clk); strobe = 1'b0;
    repeat (8) @(negedge clk);
    check("overrun_flag", 32'(err_overrun), 32'd1);
    check("overrun_y_out", 32'(y_out), 32'h0123);

    // Partial load then sample
    send(8'hA1, 1'b1, 1'b1, 1'b0, '0);
    send(8'hA2, 1'b1, 1'b1, 1'b0, '0);
    send(8'h77, 1'b0, 1'b0, 1'b0, '0);
    check("partial_ready", 32'(coeffs_ready), 32'd0);
    check("partial_nocoef", 32'(err_nocoef), 32'd1);
    check("partial_idx", 32'(coeff_idx), 32'd2);
    send(8'hA3, 1'b1, 1'b1, 1'b0, '0);
    send(8'hA4, 1'b1, 1'b1, 1'b0, '0);
    check("partial_complete_ready", 32'(coeffs_ready), 32'd1);
    check("partial_complete_idx", 32'(coeff_idx), 32'd0);

    // Reset during WAIT
    fir_y = 14'h3FFF;
    @(negedge clk);
    k = cyc;
    din = 8'h22; mode = 1'b0; strobe = 1'b1;
    tv_q.push_back('{sc: 1'b0, x: 8'h22, cyc: k + 3});
    repeat (4) @(negedge clk);
    check("busy_before_reset", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset_mid_wait",
          32'({fir_x, fir_tvalid, fir_set_coeffs, y_out, y_valid, coeffs_ready,
               coeff_idx, busy, err_nocoef, err_overrun}), 32'd0);
    strobe = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    send(8'h44, 1'b0, 1'b0, 1'b0, '0);
    check("after_reset_nocoef", 32'(err_nocoef), 32'd1);
    check("after_reset_ready", 32'(coeffs_ready), 32'd0);

    repeat (4) @(negedge clk);
    check("tv_queue_empty", 32'(tv_q.size()), 32'd0);
    check("y_queue_empty", 32'(y_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/fir_seq_ctrl.md
Name: fir_seq_ctrl

Overview:
Sequencer between the pin-level byte interface and the FIR datapath.
- Converts slow, asynchronous strobe/mode pins into single-cycle FIR handshakes.
- Loads a full coefficient set (NUM_TAPS bytes), then issues samples.
- Waits the FIR pipeline latency after each sample, then captures the 14-bit result.
- Flags protocol errors: sample before coefficients are ready, strobe while busy.

Parameters:
NUM_TAPS, 4, coefficient bytes per full set (≥2); coeff_idx width = clog2(NUM_TAPS)
FIR_LATENCY, 2, cycles from fir_tvalid high to a valid fir_y (≥1)
DATA_W, 8, sample/coefficient width
OUT_W, 14, FIR result width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  design enable; when low, strobe edges are ignored
din  in  DATA_W  byte from pins, sampled at the detected strobe edge
strobe  in  1  async pin; a rising edge requests one transfer
mode  in  1  1 = coefficient byte, 0 = sample byte; sampled with din
fir_x  out  DATA_W  byte to the FIR
fir_tvalid  out  1  one-cycle transfer strobe to the FIR
fir_set_coeffs  out  1  qualifies fir_tvalid as a coefficient write
fir_y  in  OUT_W  FIR output
y_out  out  OUT_W  captured result, held until the next capture
y_valid  out  1  one-cycle pulse when y_out updates
coeffs_ready  out  1  a full coefficient set is loaded
coeff_idx  out  clog2(NUM_TAPS)  next coefficient slot
busy  out  1  state is WAIT or CAPTURE
err_nocoef  out  1  sticky: sample rejected because coeffs_ready=0 or a load was partial
err_overrun  out  1  sticky: strobe edge arrived while busy

Behaviour:
- Reset (async, rst_n=0): all outputs, synchronizer flops, counters and sticky flags go to 0; state=IDLE. Applies immediately in any state, including mid-load or mid-wait.
- strobe passes through a 2-FF synchronizer plus a third delay flop. The event is sync2 & ~sync3 & ena. din and mode are captured in the event cycle.
- Pin timing: din and mode must be stable from the strobe rise until 3 cycles after it.
- fir_x, fir_tvalid and fir_set_coeffs are registered. fir_tvalid is high for exactly 1 cycle, 3 cycles after strobe is first sampled high. fir_x holds its value until the next transfer.
- States: IDLE, WAIT, CAPTURE.
- IDLE, event with mode=1 (coefficient byte):
  - Issue fir_tvalid=1, fir_set_coeffs=1, fir_x=din.
  - If coeff_idx==0, clear coeffs_ready.
  - If coeff_idx==NUM_TAPS-1, set coeff_idx=0 and coeffs_ready=1. Otherwise increment coeff_idx.
  - Stay in IDLE.
- IDLE, event with mode=0 (sample byte):
  - If coeffs_ready=0 or coeff_idx≠0: no FIR transfer, set err_nocoef, stay in IDLE. coeff_idx is kept.
  - Otherwise: issue fir_tvalid=1, fir_set_coeffs=0, fir_x=din, load the wait counter with FIR_LATENCY-1, go to WAIT.
- WAIT: decrement the counter each cycle; at 0 go to CAPTURE. Events are dropped and set err_overrun.
- CAPTURE (1 cycle): y_out<=fir_y, y_valid=1 in the following cycle, go to IDLE. An event here is dropped and sets err_overrun.
- Sample latency: y_valid is high exactly FIR_LATENCY+1 cycles after the fir_tvalid cycle. fir_y is sampled FIR_LATENCY cycles after fir_tvalid.
- fir_set_coeffs is 0 whenever fir_tvalid is 0.
- Sticky flags clear only on reset.
- ena low: no new events are detected; an in-flight WAIT/CAPTURE still completes.

Test Plan:
- Reset then NUM_TAPS=4 coefficient strobes, din=1,2,3,4 -> four 1-cycle fir_tvalid with fir_set_coeffs=1 and fir_x=1..4; coeff_idx 1,2,3,0; coeffs_ready=1 after the 4th.
- Sample strobe before any load, din=0x55 -> no fir_tvalid; err_nocoef=1; y_valid stays 0.
- After load, sample din=0x10 with stub fir_y=0x1ABC -> fir_tvalid at +3 cycles; y_valid at tvalid+3 (FIR_LATENCY=2); y_out=0x1ABC, held afterwards.
- Second sample strobe landing during WAIT -> ignored, err_overrun=1, exactly one y_valid.
- 2 of 4 coefficients loaded, then a sample strobe -> coeffs_ready=0, err_nocoef=1, coeff_idx=2 kept; 2 more coefficients -> coeffs_ready=1.
- rst_n pulsed low during WAIT -> outputs immediately 0, no y_valid; next sample rejected (coeffs_ready=0).
